axi_read_responder: RTL and testbench
=====================================

AXI_READ_RESPONDER -- requirements
Module: axi_read_responder

Interface
REQ-001 Parameters SHALL be: C_S_AXI_ID_WIDTH=1 (ID width); C_S_AXI_ADDR_WIDTH=32 (address width); C_S_AXI_DATA_WIDTH=32 (data width, fixed); C_S_AXI_RUSER_WIDTH=4 (RUSER width); C_BASE_ADDR=32'h2000_0000 (window base); C_MEM_WORDS=1024 (memory depth in 32-bit words, power of two).
REQ-002 CLK  in  1  clock; all logic on rising edge.
REQ-003 RST  in  1  reset, synchronous, active-high.
REQ-004 LOAD_WE  in  1  preload write strobe.
REQ-005 LOAD_ADDR  in  log2(C_MEM_WORDS)  preload word index.
REQ-006 LOAD_DATA  in  32  preload data.
REQ-007 S_AXI_ARID/ARADDR/ARLEN[8]/ARSIZE[3]/ARBURST[2]/ARLOCK[2]/ARCACHE[4]/ARPROT[3]/ARQOS[4]/ARUSER  in  per parameter  AR payload.
REQ-008 S_AXI_ARVALID  in  1; S_AXI_ARREADY  out  1.
REQ-009 S_AXI_RID  out  ID width; S_AXI_RDATA  out  32; S_AXI_RRESP  out  2; S_AXI_RLAST  out  1; S_AXI_RUSER  out  RUSER width (always 0); S_AXI_RVALID  out  1; S_AXI_RREADY  in  1.

Function
REQ-010 The block SHALL be a read-only AXI4 slave answering one burst at a time; no write channels.
REQ-011 State machine SHALL have states IDLE, READ; IDLE->READ on ARVALID&&ARREADY; READ->IDLE on RVALID&&RREADY&&RLAST.
REQ-012 ARREADY SHALL be 1 exactly in IDLE (not RST); 0 in READ.
REQ-013 On AR handshake the block SHALL latch ARID, word index ARADDR[log2(C_MEM_WORDS)+1:2], beat count ARLEN+1, and in-window flag (ARADDR[31:12+] equal to C_BASE_ADDR upper bits, window = 4*C_MEM_WORDS bytes).
REQ-014 ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARQOS, ARUSER SHALL be ignored; every burst is INCR of 4-byte beats.
REQ-015 Word index SHALL increment by 1 per beat issued and wrap modulo C_MEM_WORDS (index C_MEM_WORDS-1 followed by 0).
REQ-016 Memory read latency SHALL be 1 cycle; first RVALID SHALL assert 2 cycles after the AR handshake cycle.
REQ-017 With RREADY held 1, beats SHALL issue one per cycle with no bubbles.
REQ-018 While RVALID&&!RREADY, RDATA, RID, RRESP, RLAST SHALL hold stable; no data lost (2-entry skid buffer or read-enable stall).
REQ-019 RID SHALL equal latched ARID for every beat; RLAST SHALL be 1 only on beat ARLEN+1.
REQ-020 In-window burst: RRESP=2'b00 (OKAY), RDATA=memory word; out-of-window burst: RRESP=2'b10 (SLVERR), RDATA=0, still ARLEN+1 beats.
REQ-021 LOAD_WE SHALL write LOAD_DATA to LOAD_ADDR on that edge; simultaneous load and read of the same word SHALL return the old data (read-first).
REQ-022 ARLEN=0 SHALL produce a single beat with RLAST=1.
REQ-023 A new AR SHALL NOT be accepted in the cycle the last beat completes; ARREADY rises the following cycle.

Reset
REQ-024 RST SHALL force: state IDLE, ARREADY=0 during RST then 1 the cycle after, RVALID=0, RLAST=0, RRESP=0, RID=0, RDATA=0, skid buffer empty.
REQ-025 RST mid-burst SHALL abort the burst (RVALID=0 next cycle, no further beats); memory contents SHALL be preserved.

Structure
REQ-026 Shared package SHALL hold AXI response codes (OKAY=2'b00, SLVERR=2'b10), state encodings (IDLE=2'b00, READ=2'b01), and default C_BASE_ADDR.
REQ-027 Storage SHALL be one sub-module, bram_sdp_4kb (1 write port, 1 read port, 1-cycle registered read, read-first); control, counters and skid buffer stay in axi_read_responder.

Verification
REQ-028 Preload word i = 32'h1000_0000+i; AR addr 0x2000_0000, ARLEN=0x1F, ARID=1, RREADY=1 -> 32 beats 0x1000_0000..0x1000_001F back-to-back, RLAST on beat 32, RID=1, RRESP=0.
REQ-029 Same burst with RREADY toggled 1,0,0,1 repeating -> identical 32-word sequence, outputs stable while stalled, no duplicates or drops.
REQ-030 32 consecutive bursts ARLEN=0x1F at 0x2000_0000 + 128*k -> all 1024 words returned in order.
REQ-031 AR addr 0x2000_0FF8, ARLEN=3 -> data of words 1022, 1023, 0, 1.
REQ-032 AR addr 0x3000_0000, ARLEN=2 -> 3 beats, RRESP=2'b10, RDATA=0, RLAST on beat 3.
REQ-033 RST asserted at beat 5 of a 32-beat burst -> RVALID=0 next cycle, ARREADY=1 after RST release, next burst returns preloaded data intact.

Source files
------------

// File: rtl/axi_read_responder_pkg.sv
// Shared constants for the AXI read responder: response codes, FSM encodings
// and the default address window base.
package axi_read_responder_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_READ = 2'b01;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h2000_0000;

endpackage

// File: rtl/bram_sdp_4kb.sv
// Simple dual-port RAM: one write port, one registered read port, read-first.
// Contents are never cleared by reset.
module bram_sdp_4kb #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH),
    parameter int DW    = 32
) (
    input  logic          CLK,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    // Both ports sample mem before this edge's write lands, giving read-first.
    always_ff @(posedge CLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/axi_read_responder.sv
// Read-only AXI4 slave serving INCR bursts of 32-bit words from an internal RAM,
// one burst at a time; out-of-window bursts answer SLVERR with zero data.
module axi_read_responder
    import axi_read_responder_pkg::*;
#(
    parameter int C_S_AXI_ID_WIDTH     = 1,
    parameter int C_S_AXI_ADDR_WIDTH   = 32,
    parameter int C_S_AXI_DATA_WIDTH   = 32,
    parameter int C_S_AXI_RUSER_WIDTH  = 4,
    parameter int C_S_AXI_ARUSER_WIDTH = 1,
    parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int C_MEM_WORDS          = 1024,
    parameter int AW                   = $clog2(C_MEM_WORDS)
) (
    input  logic                            CLK,
    input  logic                            RST,

    input  logic                            LOAD_WE,
    input  logic [AW-1:0]                   LOAD_ADDR,
    input  logic [31:0]                     LOAD_DATA,

    input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_ARID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [7:0]                      S_AXI_ARLEN,
    input  logic [2:0]                      S_AXI_ARSIZE,
    input  logic [1:0]                      S_AXI_ARBURST,
    input  logic [1:0]                      S_AXI_ARLOCK,
    input  logic [3:0]                      S_AXI_ARCACHE,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic [3:0]                      S_AXI_ARQOS,
    input  logic [C_S_AXI_ARUSER_WIDTH-1:0] S_AXI_ARUSER,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,

    output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_RID,
    output logic [31:0]                     S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RLAST,
    output logic [C_S_AXI_RUSER_WIDTH-1:0]  S_AXI_RUSER,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,

    output logic [1:0]                      DBG_STATE
);

    localparam logic [AW-1:0] IDX_ONE = 1;

    logic [1:0]                  state;
    logic [AW-1:0]               rd_idx;
    logic [8:0]                  issue_left;
    logic                        in_win;
    logic [C_S_AXI_ID_WIDTH-1:0] id_q;
    logic                        out_valid;
    logic                        out_last;
    logic [1:0]                  out_resp;
    logic [31:0]                 mem_q;

    logic ar_hs;
    logic r_hs;
    logic issue;
    logic addr_in_win;
    logic unused_ar;

    // Handshakes: a transfer happens on any rising edge where VALID and READY
    // are both high; VALID never waits for READY, and the payload stays
    // stable from VALID rising until that transfer edge.
    assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;
    assign r_hs  = out_valid && S_AXI_RREADY;

    // The RAM output register is the only beat store: a new read is issued only
    // when that slot is empty or draining, so a stall simply freezes the RAM.
    assign issue = (state == ST_READ) && (issue_left != 9'd0) &&
                   (!out_valid || S_AXI_RREADY);

    assign addr_in_win = (S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:AW+2] ==
                          C_BASE_ADDR[C_S_AXI_ADDR_WIDTH-1:AW+2]);

    assign unused_ar = ^{S_AXI_ARSIZE, S_AXI_ARBURST, S_AXI_ARLOCK, S_AXI_ARCACHE,
                         S_AXI_ARPROT, S_AXI_ARQOS, S_AXI_ARUSER, S_AXI_ARADDR[1:0]};

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= ST_IDLE;
            rd_idx     <= '0;
            issue_left <= '0;
            in_win     <= 1'b0;
            id_q       <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_resp   <= AXI_RESP_OKAY;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ar_hs) begin
                        state      <= ST_READ;
                        rd_idx     <= S_AXI_ARADDR[AW+1:2];
                        issue_left <= {1'b0, S_AXI_ARLEN} + 9'd1;
                        in_win     <= addr_in_win;
                        id_q       <= S_AXI_ARID;
                    end
                end
                ST_READ: begin
                    if (r_hs && out_last) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (issue) begin
                rd_idx     <= rd_idx + IDX_ONE;
                issue_left <= issue_left - 9'd1;
                out_valid  <= 1'b1;
                out_last   <= (issue_left == 9'd1);
                out_resp   <= in_win ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
            end else if (r_hs) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                out_resp  <= AXI_RESP_OKAY;
            end
        end
    end

    bram_sdp_4kb #(
        .DEPTH (C_MEM_WORDS),
        .AW    (AW),
        .DW    (32)
    ) u_mem (
        .CLK   (CLK),
        .we    (LOAD_WE),
        .waddr (LOAD_ADDR),
        .wdata (LOAD_DATA),
        .re    (issue),
        .raddr (rd_idx),
        .rdata (mem_q)
    );

    assign S_AXI_ARREADY = (state == ST_IDLE) && !RST;
    assign S_AXI_RVALID  = out_valid;
    assign S_AXI_RLAST   = out_last;
    assign S_AXI_RRESP   = out_resp;
    assign S_AXI_RID     = id_q;
    assign S_AXI_RDATA   = (out_valid && out_resp == AXI_RESP_OKAY) ? mem_q : 32'd0;
    assign S_AXI_RUSER   = '0;
    assign DBG_STATE     = state;

endmodule

// File: tb/tb_axi_read_responder.sv
// Directed bench for axi_read_responder: preload, bursts, stalls, wrap,
// out-of-window, mid-burst reset and read-first load collision.
module tb_axi_read_responder;
    import axi_read_responder_pkg::*;

    logic        CLK;
    logic        RST;
    logic        LOAD_WE;
    logic [9:0]  LOAD_ADDR;
    logic [31:0] LOAD_DATA;
    logic [0:0]  S_AXI_ARID;
    logic [31:0] S_AXI_ARADDR;
    logic [7:0]  S_AXI_ARLEN;
    logic [2:0]  S_AXI_ARSIZE;
    logic [1:0]  S_AXI_ARBURST;
    logic [1:0]  S_AXI_ARLOCK;
    logic [3:0]  S_AXI_ARCACHE;
    logic [2:0]  S_AXI_ARPROT;
    logic [3:0]  S_AXI_ARQOS;
    logic [0:0]  S_AXI_ARUSER;
    logic        S_AXI_ARVALID;
    logic        S_AXI_ARREADY;
    logic [0:0]  S_AXI_RID;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RLAST;
    logic [3:0]  S_AXI_RUSER;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY;
    logic [1:0]  DBG_STATE;

    int vec_cnt = 0;
    int err_cnt = 0;
    logic [31:0] exp_q[$];

    axi_read_responder dut (
        .CLK(CLK), .RST(RST),
        .LOAD_WE(LOAD_WE), .LOAD_ADDR(LOAD_ADDR), .LOAD_DATA(LOAD_DATA),
        .S_AXI_ARID(S_AXI_ARID), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARLEN(S_AXI_ARLEN),
        .S_AXI_ARSIZE(S_AXI_ARSIZE), .S_AXI_ARBURST(S_AXI_ARBURST), .S_AXI_ARLOCK(S_AXI_ARLOCK),
        .S_AXI_ARCACHE(S_AXI_ARCACHE), .S_AXI_ARPROT(S_AXI_ARPROT), .S_AXI_ARQOS(S_AXI_ARQOS),
        .S_AXI_ARUSER(S_AXI_ARUSER), .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RID(S_AXI_RID), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RLAST(S_AXI_RLAST), .S_AXI_RUSER(S_AXI_RUSER), .S_AXI_RVALID(S_AXI_RVALID),
        .S_AXI_RREADY(S_AXI_RREADY), .DBG_STATE(DBG_STATE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load_word(input int idx, input logic [31:0] data);
        LOAD_WE   = 1'b1;
        LOAD_ADDR = 10'(idx);
        LOAD_DATA = data;
        @(negedge CLK);
        LOAD_WE   = 1'b0;
    endtask

    // Presents one AR for a single cycle; returns at the negedge of the cycle after.
    task automatic do_ar(input logic id, input logic [31:0] addr, input logic [7:0] len);
        check("arready_idle", 64'(S_AXI_ARREADY), 64'd1);
        S_AXI_ARID    = id;
        S_AXI_ARADDR  = addr;
        S_AXI_ARLEN   = len;
        S_AXI_ARSIZE  = 3'($urandom_range(0, 7));
        S_AXI_ARBURST = 2'($urandom_range(0, 3));
        S_AXI_ARVALID = 1'b1;
        @(negedge CLK);
        S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY  = 1'b1;
    endtask

    task automatic push_words(input int first, input int n, input logic zero);
        for (int i = 0; i < n; i++)
            exp_q.push_back(zero ? 32'd0 : 32'h1000_0000 + 32'((first + i) % 1024));
    endtask

    task automatic recv_burst(input int n, input logic stall, input logic [1:0] exp_resp,
                              input logic exp_id, input int abort_at);
        int beats, cyc, first_cyc;
        logic held, held_last;
        logic [31:0] held_data, exp_d;
        beats = 0; cyc = 0; first_cyc = -1; held = 1'b0; held_last = 1'b0; held_data = '0;
        while (beats < n && !(abort_at > 0 && beats == abort_at) && cyc < 4000) begin
            S_AXI_RREADY = stall ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            if (held) begin
                check("stall_rvalid", 64'(S_AXI_RVALID), 64'd1);
                check("stall_rdata", 64'(S_AXI_RDATA), 64'(held_data));
                check("stall_rlast", 64'(S_AXI_RLAST), 64'(held_last));
            end
            held = 1'b0;
            if (S_AXI_RVALID) begin
                if (first_cyc < 0) first_cyc = cyc;
                check("arready_busy", 64'(S_AXI_ARREADY), 64'd0);
                if (S_AXI_RREADY) begin
                    exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
                    check("rdata", 64'(S_AXI_RDATA), 64'(exp_d));
                    check("rresp", 64'(S_AXI_RRESP), 64'(exp_resp));
                    check("rid", 64'(S_AXI_RID), 64'(exp_id));
                    check("rlast", 64'(S_AXI_RLAST), 64'(beats == n - 1));
                    beats++;
                end else begin
                    held = 1'b1;
                    held_data = S_AXI_RDATA;
                    held_last = S_AXI_RLAST;
                end
            end
            cyc++;
            @(negedge CLK);
        end
        check("beat_count", 64'(beats), 64'((abort_at > 0) ? abort_at : n));
        check("first_latency", 64'(first_cyc), 64'd1);
        if (!stall && abort_at == 0) check("no_bubbles", 64'(cyc), 64'(n + 1));
    endtask

    initial begin
        RST = 1'b1; LOAD_WE = 1'b0; LOAD_ADDR = '0; LOAD_DATA = '0;
        S_AXI_ARID = '0; S_AXI_ARADDR = '0; S_AXI_ARLEN = '0; S_AXI_ARSIZE = 3'd2;
        S_AXI_ARBURST = 2'd1; S_AXI_ARLOCK = '0; S_AXI_ARCACHE = '0; S_AXI_ARPROT = '0;
        S_AXI_ARQOS = '0; S_AXI_ARUSER = '0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;

        // Reset state
        repeat (3) @(negedge CLK);
        check("rst_arready", 64'(S_AXI_ARREADY), 64'd0);
        check("rst_rvalid", 64'(S_AXI_RVALID), 64'd0);
        check("rst_rlast", 64'(S_AXI_RLAST), 64'd0);
        check("rst_rresp", 64'(S_AXI_RRESP), 64'd0);
        check("rst_rid", 64'(S_AXI_RID), 64'd0);
        check("rst_rdata", 64'(S_AXI_RDATA), 64'd0);
        check("rst_ruser", 64'(S_AXI_RUSER), 64'd0);
        RST = 1'b0;
        @(negedge CLK);
        check("post_rst_arready", 64'(S_AXI_ARREADY), 64'd1);

        for (int i = 0; i < 1024; i++) load_word(i, 32'h1000_0000 + 32'(i));

        // 32-beat burst, RREADY held high
        push_words(0, 32, 1'b0);
        do_ar(1'b1, 32'h2000_0000, 8'h1F);
        recv_burst(32, 1'b0, AXI_RESP_OKAY, 1'b1, 0);

        // Same burst with RREADY toggling 1,0,0,1
        push_words(0, 32, 1'b0);
        do_ar(1'b1, 32'h2000_0000, 8'h1F);
        recv_burst(32, 1'b1, AXI_RESP_OKAY, 1'b1, 0);

        // Whole memory in 32 consecutive bursts
        for (int k = 0; k < 32; k++) begin
            push_words(32 * k, 32, 1'b0);
            do_ar(1'(k), 32'h2000_0000 + 32'(128 * k), 8'h1F);
            recv_burst(32, 1'b0, AXI_RESP_OKAY, 1'(k), 0);
        end

        // Index wrap 1022, 1023, 0, 1
        push_words(1022, 4, 1'b0);
        do_ar(1'b0, 32'h2000_0FF8, 8'd3);
        recv_burst(4, 1'b0, AXI_RESP_OKAY, 1'b0, 0);

        // Single-beat burst
        push_words(4, 1, 1'b0);
        do_ar(1'b1, 32'h2000_0010, 8'd0);
        recv_burst(1, 1'b0, AXI_RESP_OKAY, 1'b1, 0);

        // Out of window
        push_words(0, 3, 1'b1);
        do_ar(1'b0, 32'h3000_0000, 8'd2);
        recv_burst(3, 1'b1, AXI_RESP_SLVERR, 1'b0, 0);

        // Reset at beat 5 of a 32-beat burst
        push_words(0, 32, 1'b0);
        do_ar(1'b1, 32'h2000_0000, 8'h1F);
        recv_burst(32, 1'b0, AXI_RESP_OKAY, 1'b1, 5);
        exp_q.delete();
        RST = 1'b1;
        @(negedge CLK);
        check("abort_rvalid", 64'(S_AXI_RVALID), 64'd0);
        check("abort_arready_in_rst", 64'(S_AXI_ARREADY), 64'd0);
        RST = 1'b0;
        @(negedge CLK);
        check("abort_arready_after", 64'(S_AXI_ARREADY), 64'd1);
        check("abort_rvalid_after", 64'(S_AXI_RVALID), 64'd0);
        push_words(0, 8, 1'b0);
        do_ar(1'b0, 32'h2000_0000, 8'd7);
        recv_burst(8, 1'b0, AXI_RESP_OKAY, 1'b0, 0);

        // Load colliding with the read of word 5 returns the old word
        do_ar(1'b0, 32'h2000_0014, 8'd0);
        LOAD_WE = 1'b1; LOAD_ADDR = 10'd5; LOAD_DATA = 32'hDEAD_BEEF;
        @(negedge CLK);
        LOAD_WE = 1'b0;
        check("rf_rvalid", 64'(S_AXI_RVALID), 64'd1);
        check("rf_old_data", 64'(S_AXI_RDATA), 64'h1000_0005);
        check("rf_rlast", 64'(S_AXI_RLAST), 64'd1);
        @(negedge CLK);
        check("rf_done", 64'(S_AXI_RVALID), 64'd0);
        exp_q.push_back(32'hDEAD_BEEF);
        do_ar(1'b1, 32'h2000_0014, 8'd0);
        recv_burst(1, 1'b0, AXI_RESP_OKAY, 1'b1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
